pm_reset_seq: RTL and testbench



---
 rtl/pm_reset_seq.sv | 125 ++++++++++++
 tb/tb_pm_reset_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pm_reset_seq.sv
// pm_reset_seq: N_CH reset synchroniser and ordered release sequencer; define PM_RESET_SEQ_ACK_EN for per-channel release acks
module pm_reset_seq #(
  parameter int N_CH      = 4,
  parameter int SYNC_FF   = 3,
  parameter int MIN_PULSE = 8,
`ifdef PM_RESET_SEQ_ACK_EN
  parameter int ACK_TO    = 1024,
`endif
  parameter int REL_GAP   = 4
) (
  input  logic            dest_clk,
  input  logic            rst_n_in,
  input  logic [N_CH-1:0] rst_req_in,
`ifdef PM_RESET_SEQ_ACK_EN
  input  logic [N_CH-1:0] rst_ack_in,
  output logic            ack_err,
`endif
  output logic [N_CH-1:0] rst_out,
  output logic            seq_busy,
  output logic            seq_done
);
  localparam int IW = $clog2(N_CH + 1);
`ifdef PM_RESET_SEQ_ACK_EN
  typedef enum logic [1:0] {HOLD, GAP, DONE, WAIT_ACK} state_t;
`else
  typedef enum logic [1:0] {HOLD, GAP, DONE} state_t;
`endif
  state_t          state, state_n;
  logic [15:0]     cnt, cnt_n;
  logic [IW-1:0]   rel_idx, idx_n, k;
  logic [N_CH-1:0] sreq, ro_n;
  logic            done_n, fire, last;
  // requests set the chain asynchronously; only their removal is synchronised
  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    logic [SYNC_FF-1:0] c;
    logic               r;
    assign r = rst_req_in[g];
    always_ff @(posedge dest_clk or negedge rst_n_in or posedge r)
      if (!rst_n_in) c <= '1;
      else if (r) c <= '1;
      else c <= {c[SYNC_FF-2:0], 1'b0};
    assign sreq[g] = c[SYNC_FF-1];
  end
`ifdef PM_RESET_SEQ_ACK_EN
  logic [N_CH-1:0] sack;
  logic            err_n, acked;
  for (genvar g = 0; g < N_CH; g++) begin : g_ack
    logic [SYNC_FF-1:0] c;
    always_ff @(posedge dest_clk or negedge rst_n_in)
      if (!rst_n_in) c <= '0;
      else c <= {c[SYNC_FF-2:0], rst_ack_in[g]};
    assign sack[g] = c[SYNC_FF-1];
  end
`endif
  always_ff @(posedge dest_clk or negedge rst_n_in)
    if (!rst_n_in) begin
      state    <= HOLD;
      cnt      <= '0;
      rel_idx  <= '0;
      rst_out  <= '1;
      seq_done <= 1'b0;
`ifdef PM_RESET_SEQ_ACK_EN
      ack_err  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rel_idx  <= idx_n;
      rst_out  <= ro_n;
      seq_done <= done_n;
`ifdef PM_RESET_SEQ_ACK_EN
      ack_err  <= err_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = rel_idx;
    ro_n    = rst_out;
    done_n  = seq_done;
    fire    = 1'b0;
    last    = rel_idx == IW'(N_CH - 1);
    k       = '0;
`ifdef PM_RESET_SEQ_ACK_EN
    err_n   = ack_err;
    acked   = 1'b0;
    for (int i = 0; i < N_CH; i++) if (IW'(i + 1) == rel_idx) acked = sack[i];
`endif
    for (int i = N_CH - 1; i >= 0; i--) if (sreq[i]) k = IW'(i);
    if (|sreq) begin
      for (int i = 0; i < N_CH; i++) if (IW'(i) >= k) ro_n[i] = 1'b1;
      idx_n   = k < rel_idx ? k : rel_idx;
      cnt_n   = '0;
      state_n = HOLD;
      done_n  = 1'b0;
    end else begin
      if (state == HOLD || state == GAP) begin
        cnt_n = cnt + 16'd1;
        fire  = cnt == (state == HOLD ? 16'(MIN_PULSE - 1) : 16'(REL_GAP - 1));
      end
`ifdef PM_RESET_SEQ_ACK_EN
      if (state == WAIT_ACK) begin
        cnt_n = cnt + 16'd1;
        if (acked || cnt == 16'(ACK_TO)) begin
          state_n = GAP;
          cnt_n   = '0;
          err_n   = ack_err | ~acked;
        end
      end
`endif
      if (fire) begin
        for (int i = 0; i < N_CH; i++) if (IW'(i) == rel_idx) ro_n[i] = 1'b0;
        idx_n  = rel_idx + 1'b1;
        cnt_n  = '0;
        done_n = last;
`ifdef PM_RESET_SEQ_ACK_EN
        state_n = last ? DONE : WAIT_ACK;
`else
        state_n = last ? DONE : GAP;
`endif
      end
    end
  end
  assign seq_busy = ~seq_done;
endmodule

// File: tb/tb_pm_reset_seq.sv
// tb_pm_reset_seq: directed and random stimulus for pm_reset_seq against a release-schedule model
module tb_pm_reset_seq;
  localparam int N_CH = 4, SYNC_FF = 3, MIN_PULSE = 8, REL_GAP = 4;
  logic            dest_clk = 1'b0;
  logic            rst_n_in = 1'b1;
  logic [N_CH-1:0] rst_req_in = '0;
  logic [N_CH-1:0] rst_out;
  logic            seq_busy, seq_done;
  int n_chk = 0, n_fail = 0;
  int lowcnt [N_CH];
  bit rel [N_CH];
  int t0, first, edge_n = 0;
  int fall [N_CH];
  int done_at;

  pm_reset_seq #(.N_CH(N_CH), .SYNC_FF(SYNC_FF), .MIN_PULSE(MIN_PULSE), .REL_GAP(REL_GAP)) dut (
    .dest_clk(dest_clk), .rst_n_in(rst_n_in), .rst_req_in(rst_req_in),
    .rst_out(rst_out), .seq_busy(seq_busy), .seq_done(seq_done));

  always #5 dest_clk = ~dest_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] exp_out();
    logic [N_CH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i] = !rel[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      lowcnt[i] = 0;
      rel[i] = 0;
    end
    t0 = -1;
  endtask

  // channel i of a sequence starting at "first" leaves reset at t0+MIN_PULSE-1+(i-first)*REL_GAP
  task automatic model_edge();
    bit any = 0;
    int k = 0;
    if (!rst_n_in) begin
      model_reset();
      edge_n++;
      return;
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rst_req_in[i] || lowcnt[i] < SYNC_FF) begin
        any = 1;
        k = i;
      end
      lowcnt[i] = rst_req_in[i] ? 0 : (lowcnt[i] < SYNC_FF ? lowcnt[i] + 1 : lowcnt[i]);
    end
    if (any) begin
      for (int i = k; i < N_CH; i++) rel[i] = 0;
      t0 = -1;
    end else begin
      if (t0 < 0) begin
        t0 = edge_n;
        first = N_CH;
        for (int i = N_CH - 1; i >= 0; i--) if (!rel[i]) first = i;
      end
      for (int i = first; i < N_CH; i++)
        if (edge_n == t0 + MIN_PULSE - 1 + (i - first) * REL_GAP) rel[i] = 1;
    end
    edge_n++;
  endtask

  task automatic tick();
    @(posedge dest_clk);
    model_edge();
    @(negedge dest_clk);
    check("rst_out", 32'(rst_out), 32'(exp_out()));
    check("seq_done", 32'(seq_done), 32'(exp_out() == '0));
    check("seq_busy", 32'(seq_busy), 32'(exp_out() != '0));
  endtask

  task automatic wait_exp(input string tag, input logic [N_CH-1:0] target, input int budget);
    for (int n = 0; n < budget && exp_out() != target; n++) tick();
    check(tag, 32'(rst_out), 32'(target));
  endtask

  task automatic track(input int n);
    for (int i = 0; i < N_CH; i++) fall[i] = -1;
    done_at = -1;
    for (int j = 1; j <= n; j++) begin
      tick();
      for (int i = 0; i < N_CH; i++) if (fall[i] < 0 && !rst_out[i]) fall[i] = j;
      if (done_at < 0 && seq_done) done_at = j;
    end
  endtask

  task automatic restart();
    rst_req_in[0] = 1'b1;
    tick();
    rst_req_in[0] = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 rst_n_in = 1'b0;
    #1;
    check("reset_out", 32'(rst_out), 32'hF);
    check("reset_busy", 32'(seq_busy), 32'd1);
    check("reset_done", 32'(seq_done), 32'd0);
    tick();
    tick();
    rst_n_in = 1'b1;
    track(30);
    for (int i = 0; i < N_CH; i++) check($sformatf("init_fall%0d", i), 32'(fall[i]), 32'(11 + 4 * i));
    check("init_done_at", 32'(done_at), 32'd23);

    rst_req_in[2] = 1'b1;
    tick();
    check("pulse2_out", 32'(rst_out), 32'hC);
    rst_req_in[2] = 1'b0;
    track(25);
    check("pulse2_fall2", 32'(fall[2]), 32'd11);
    check("pulse2_fall3", 32'(fall[3]), 32'd15);

    restart();
    wait_exp("gap_reach", 4'b1110, 100);
    rst_req_in[0] = 1'b1;
    tick();
    check("gap_req_out", 32'(rst_out), 32'hF);
    repeat (19) tick();
    rst_req_in[0] = 1'b0;
    track(40);
    check("gap_fall0", 32'(fall[0]), 32'd11);
    check("gap_fall1", 32'(fall[1]), 32'd15);
    check("gap_done_at", 32'(done_at), 32'd23);

    restart();
    wait_exp("coinc_reach", 4'b1000, 100);
    repeat (3) tick();
    rst_req_in[3] = 1'b1;
    tick();
    check("coinc_out", 32'(rst_out), 32'h8);
    check("coinc_done", 32'(seq_done), 32'd0);
    rst_req_in[3] = 1'b0;
    repeat (30) tick();

    restart();
    wait_exp("arst_reach", 4'b1100, 100);
    tick();
    #2 rst_n_in = 1'b0;
    model_reset();
    #1;
    check("arst_out", 32'(rst_out), 32'hF);
    check("arst_busy", 32'(seq_busy), 32'd1);
    check("arst_done", 32'(seq_done), 32'd0);
    tick();
    tick();
    rst_n_in = 1'b1;
    track(30);
    check("arst_fall0", 32'(fall[0]), 32'd11);
    check("arst_done_at", 32'(done_at), 32'd23);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst_n_in = 1'b0;
        model_reset();
        #1;
        check("rnd_arst_out", 32'(rst_out), 32'hF);
        tick();
        rst_n_in = 1'b1;
      end
      for (int i = 0; i < N_CH; i++) rst_req_in[i] = $urandom_range(0, 99) < 1;
      tick();
    end
    rst_req_in = '0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
